// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio helpers: unity volume, slot conversion, shift-and-clamp
package audio_pkg;

    localparam int VOL_ONE = 256;

    // Flip the MSB to recentre offset-binary on zero, then sign-extend from w bits.
    function automatic logic signed [31:0] conv_offset_bin(input logic [31:0] a, input int w);
        logic [31:0]        t;
        logic signed [31:0] r;
        t        = a;
        t[w-1]   = ~t[w-1];
        r        = $signed(t << (32 - w));
        return r >>> (32 - w);
    endfunction

    function automatic logic signed [31:0] conv_twos_gain(input logic [31:0] b, input int w, input int gain);
        logic signed [31:0] r;
        r = $signed(b << (32 - w));
        r = r >>> (32 - w);
        return r * gain;
    endfunction

    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value, input int shift,
                                                     input int out_w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = value <<< shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        return s;
    endfunction

endpackage

// File: rtl/fm_slot_sync.sv
// rtl/fm_slot_sync.sv - two-flop synchronisers for the FM phase clock and frame marker
module fm_slot_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_clk1,
    input  logic i_sel23,
    output logic o_strobe,
    output logic o_marker
);

    logic r_c1, r_c2, r_c3;
    logic r_s1, r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c1 <= 1'b0;
            r_c2 <= 1'b0;
            r_c3 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_c1 <= i_clk1;
            r_c2 <= r_c1;
            r_c3 <= r_c2;
            r_s1 <= i_sel23;
            r_s2 <= r_s1;
        end
    end

    // Marker has the same two-flop depth as r_c2, so it lines up with the falling-edge strobe.
    assign o_strobe = r_c3 & ~r_c2;
    assign o_marker = r_s2;

endmodule

// File: rtl/fm_slot_accum.sv
// rtl/fm_slot_accum.sv - integrates FM DAC slot outputs into saturated, volume-ramped PCM frames
module fm_slot_accum #(
    parameter int CH        = 2,
    parameter int IN_A_W    = 9,
    parameter int IN_B_W    = 10,
    parameter int GAIN_B    = 3,
    parameter int ACC_W     = 14,
    parameter int SHIFT     = 2,
    parameter int OUT_W     = 16,
    parameter int MAX_SLOTS = 24,
    parameter int RAMP_STEP = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mute,
    input  logic                  fm_mode,
    input  logic                  fm_clk1,
    input  logic                  fm_sel23,
    input  logic [CH*IN_A_W-1:0]  din_a,
    input  logic [CH*IN_B_W-1:0]  din_b,
    output logic [CH*OUT_W-1:0]   dout,
    output logic                  dout_valid,
    output logic                  overrun,
    output logic [4:0]            slot_cnt
);
    import audio_pkg::*;

    logic       w_strobe;
    logic       w_marker;
    logic       w_flush_now;
    logic       r_flush;
    logic       r_dout_valid;
    logic       r_overrun;
    logic [4:0] r_slot_cnt;
    logic [8:0] r_vol;
    logic [8:0] w_vol_next;
    logic [9:0] w_vol_wide;
    logic [9:0] w_vol_up;

    fm_slot_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_clk1   (fm_clk1),
        .i_sel23  (fm_sel23),
        .o_strobe (w_strobe),
        .o_marker (w_marker)
    );

    // A frame closes on the marker, or is forced closed when the slot budget runs out.
    assign w_flush_now = w_strobe & (w_marker | (r_slot_cnt == 5'(MAX_SLOTS - 1)));

    assign w_vol_wide = {1'b0, r_vol};
    assign w_vol_up   = w_vol_wide + 10'(RAMP_STEP);
    assign w_vol_next = mute ? ((w_vol_wide > 10'(RAMP_STEP)) ? 9'(w_vol_wide - 10'(RAMP_STEP)) : 9'd0)
                             : ((w_vol_up >= 10'(VOL_ONE)) ? 9'(VOL_ONE) : 9'(w_vol_up));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_slot_cnt   <= 5'd0;
            r_vol        <= 9'd0;
        end else begin
            r_flush      <= w_flush_now;
            r_dout_valid <= r_flush;
            if (r_flush)
                r_vol <= w_vol_next;
            if (w_strobe) begin
                if (w_flush_now) begin
                    r_slot_cnt <= 5'd0;
                    if (!w_marker)
                        r_overrun <= 1'b1;
                end else begin
                    r_slot_cnt <= r_slot_cnt + 5'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic signed [ACC_W-1:0]  r_value;
        logic signed [ACC_W-1:0]  r_acc;
        logic signed [ACC_W-1:0]  r_frame_sum;
        logic signed [ACC_W-1:0]  w_conv;
        logic signed [ACC_W-1:0]  w_sum;
        logic signed [63:0]       w_fs_wide;
        logic signed [OUT_W-1:0]  w_sat;
        logic signed [OUT_W+9:0]  w_prod;
        logic signed [OUT_W-1:0]  r_dout;

        assign w_conv = fm_mode ? ACC_W'(conv_offset_bin(32'(din_a[g*IN_A_W +: IN_A_W]), IN_A_W))
                                : ACC_W'(conv_twos_gain(32'(din_b[g*IN_B_W +: IN_B_W]), IN_B_W, GAIN_B));
        assign w_sum     = r_acc + r_value;
        assign w_fs_wide = {{(64 - ACC_W){r_frame_sum[ACC_W-1]}}, r_frame_sum};
        assign w_sat     = OUT_W'(sat_shift(w_fs_wide, SHIFT, OUT_W));
        // Uses the freshly stepped volume, so the first frame after reset already sees one ramp step.
        assign w_prod    = w_sat * $signed({1'b0, w_vol_next});

        always_ff @(posedge clk) begin
            if (reset) begin
                r_value     <= '0;
                r_acc       <= '0;
                r_frame_sum <= '0;
                r_dout      <= '0;
            end else begin
                r_value <= w_conv;
                if (w_strobe) begin
                    if (w_flush_now) begin
                        r_frame_sum <= w_sum;
                        r_acc       <= '0;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                if (r_flush)
                    r_dout <= OUT_W'(w_prod >>> 8);
            end
        end

        assign dout[g*OUT_W +: OUT_W] = r_dout;
    end

    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign slot_cnt   = r_slot_cnt;

endmodule
